// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared sizes and FSM encoding for the shift sequencer
package shift_seq_pkg;
   localparam int WIDTH = 64;
   localparam int STEP = 2;
   localparam int MAX_STEPS = WIDTH / STEP;
   localparam int CNT_W = 6;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/shift_step_counter.sv
// shift_step_counter: loadable down-counter tracking shifts still to perform
module shift_step_counter
   import shift_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic             clr,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_d, cnt_q;
   always_comb cnt_d = clr ? '0 : load ? load_val : (dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign cnt = cnt_q;
   assign zero = (cnt_q == '0);
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences preset-then-shift strobes for an external shift register
module shift_seq_ctrl #(
   parameter int WIDTH = shift_seq_pkg::WIDTH,
   parameter int STEP = shift_seq_pkg::STEP,
   parameter int MAX_STEPS = shift_seq_pkg::MAX_STEPS
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Operand,
   input  logic [5:0]       Steps,
   input  logic             Abort,
   output logic             SR_Preset,
   output logic             SR_En,
   output logic [WIDTH-1:0] SR_In,
   output logic             Busy,
   output logic             Done,
   output logic [5:0]       Remaining
);
   import shift_seq_pkg::*;
   // never request more shifts than the register can hold
   localparam int LIMIT = (MAX_STEPS < WIDTH / STEP) ? MAX_STEPS : WIDTH / STEP;
   localparam logic [5:0] LIM = 6'(LIMIT);
   state_t state_d, state_q;
   logic [WIDTH-1:0] op_d, op_q;
   logic take, cnt_zero;
   logic [5:0] sat_steps;
   assign take = (state_q == S_IDLE) && Start;
   assign sat_steps = (Steps > LIM) ? LIM : Steps;
   always_comb begin
      state_d = state_q;
      op_d = take ? Operand : op_q;
      case (state_q)
         S_IDLE:  state_d = Start ? S_LOAD : S_IDLE;
         S_LOAD:  state_d = Abort ? S_IDLE : cnt_zero ? S_DONE : S_SHIFT;
         S_SHIFT: state_d = Abort ? S_IDLE : (Remaining <= 6'd1) ? S_DONE : S_SHIFT;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         op_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
      end
   end
   shift_step_counter u_cnt (
      .clk      (Clk),
      .rst      (Reset),
      .load     (take),
      .dec      (state_q == S_SHIFT),
      .clr      (Abort && Busy),
      .load_val (sat_steps),
      .cnt      (Remaining),
      .zero     (cnt_zero)
   );
   // abort masks the strobes in the same cycle so no stray preset or shift lands
   assign SR_Preset = (state_q == S_LOAD) && !Abort;
   assign SR_En = (state_q == S_SHIFT) && !Abort;
   assign Busy = (state_q == S_LOAD) || (state_q == S_SHIFT);
   assign Done = (state_q == S_DONE);
   assign SR_In = op_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench driving a 64-bit, 2-bit-step shift register model
module tb_shift_seq_ctrl;
   logic clk = 0, rst, start, abort, sr_preset, sr_en, busy, done;
   logic [63:0] operand, sr_in, sr;
   logic [5:0] steps, remaining;
   int total = 0, bad = 0, cyc = 0, done_cnt = 0, en_cnt = 0, busy_cnt = 0;
   typedef struct {
      logic [63:0] op;
      logic [63:0] out;
      int n;
      int t;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   shift_seq_ctrl dut (
      .Clk(clk), .Reset(rst), .Start(start), .Operand(operand), .Steps(steps), .Abort(abort),
      .SR_Preset(sr_preset), .SR_En(sr_en), .SR_In(sr_in), .Busy(busy), .Done(done), .Remaining(remaining)
   );

   always @(posedge clk) begin
      if (sr_preset) sr <= sr_in;
      else if (sr_en) sr <= {sr[61:0], 2'b00};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sr_preset) begin
         busy_cnt = 0;
         en_cnt = 0;
         if (q.size() != 0) begin
            chk("load_rem", 64'(remaining), 64'(q[0].n));
            chk("load_in", sr_in, q[0].op);
         end
      end
      if (busy) busy_cnt++;
      if (sr_en) en_cnt++;
      if (done) begin
         done_cnt++;
         if (q.size() == 0) chk("spurious_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("out", sr, e.out);
            chk("en_cycles", 64'(en_cnt), 64'(e.n));
            chk("busy_cycles", 64'(busy_cnt), 64'(e.n + 1));
            chk("done_lat", 64'(cyc - e.t), 64'(e.n + 1));
            chk("done_rem", 64'(remaining), 0);
            chk("done_busy", 64'(busy), 0);
         end
      end
   end

   task automatic start_seq(input logic [63:0] op, input logic [5:0] st, input bit track);
      exp_t e;
      start = 1;
      operand = op;
      steps = st;
      @(posedge clk);
      #1 start = 0;
      if (track) begin
         e.op = op;
         e.n = (st > 6'd32) ? 32 : int'(st);
         e.out = op << (2 * e.n);
         e.t = cyc + 1;
         q.push_back(e);
      end
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != d0) break;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
   endtask

   task automatic run(input logic [63:0] op, input logic [5:0] st);
      @(negedge clk);
      start_seq(op, st, 1);
      wait_done();
      @(negedge clk);
      #1;
      chk("idle_busy", 64'(busy), 0);
      chk("idle_rem", 64'(remaining), 0);
      chk("idle_done", 64'(done), 0);
   endtask

   initial begin
      int d0;
      rst = 1; start = 0; abort = 0; operand = 0; steps = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in", sr_in, 0);
      chk("rst_pre", 64'(sr_preset), 0);
      chk("rst_en", 64'(sr_en), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_rem", 64'(remaining), 0);
      rst = 0;
      run(64'h3, 6'd5);
      run(64'hFF, 6'd0);
      run(64'h3, 6'd40);
      run(64'h8000_0000_0000_0001, 6'd32);
      for (int i = 0; i < 4; i++) run({$urandom, $urandom}, 6'($urandom_range(0, 40)));
      // abort on the third shift cycle of a 10-step run
      @(negedge clk);
      start_seq(64'h3, 6'd10, 0);
      repeat (3) @(posedge clk);
      #1 abort = 1;
      @(negedge clk);
      chk("abort_en", 64'(sr_en), 0);
      chk("abort_pre", 64'(sr_preset), 0);
      d0 = done_cnt;
      @(posedge clk);
      #1 abort = 0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 0);
      chk("abort_rem", 64'(remaining), 0);
      chk("abort_sr", sr, 64'h30);
      repeat (3) @(negedge clk);
      chk("abort_nodone", 64'(done_cnt - d0), 0);
      // reset mid-shift, then start on the first edge after release
      @(negedge clk);
      start_seq(64'h5, 6'd20, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_in", sr_in, 0);
      chk("mrst_en", 64'(sr_en), 0);
      chk("mrst_busy", 64'(busy), 0);
      chk("mrst_rem", 64'(remaining), 0);
      rst = 0;
      start_seq(64'h9, 6'd4, 1);
      wait_done();
      // start re-pulsed in SHIFT and DONE is dropped
      d0 = done_cnt;
      @(negedge clk);
      start_seq(64'h1, 6'd3, 1);
      @(posedge clk);
      #1 start = 1; operand = 64'hAA; steps = 6'd1;
      @(posedge clk);
      #1 start = 0;
      repeat (2) @(posedge clk);
      #1 start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (4) @(negedge clk);
      chk("rep_once", 64'(done_cnt - d0), 1);
      chk("rep_in", sr_in, 64'h1);
      chk("rep_busy", 64'(busy), 0);
      // start and abort together in IDLE: start wins
      @(negedge clk);
      abort = 1;
      start_seq(64'hC, 6'd4, 1);
      abort = 0;
      wait_done();
      // abort during DONE is ignored
      @(negedge clk);
      start_seq(64'h7, 6'd2, 1);
      repeat (3) @(posedge clk);
      #1 abort = 1;
      wait_done();
      abort = 0;
      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=stuck exp=finish");
      $fatal(1);
   end
endmodule
